// File: rtl/impuls_tx.sv
// impuls_tx: millisecond-timed impulse transmitter.
// On an accepted start it emits `count` pulses on `impuls`, each `high_ms`
// msec ticks high, separated by `low_ms` ticks low. Pulses begin on a tick
// boundary and the train ends with a one-cycle `done` strobe.
// Optional feature: define IMPULS_TX_ABORT_EN to add the `abort` input,
// which stops a running train without issuing `done`.
module impuls_tx #(
  parameter int CNT_W    = 8,
  parameter int DEF_HIGH = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             msec,
  input  logic             start,
  input  logic [CNT_W-1:0] high_ms,
  input  logic [CNT_W-1:0] low_ms,
  input  logic [CNT_W-1:0] count,
`ifdef IMPULS_TX_ABORT_EN
  input  logic             abort,
`endif
  output logic             impuls,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    HIGH,
    LOW,
    FINISH
  } state_t;

  state_t           state;
  logic             msec_d;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] high_l;
  logic [CNT_W-1:0] low_l;
  logic [CNT_W-1:0] count_l;

  logic             tick;
  logic             abort_req;
  logic [CNT_W-1:0] sent_nx;
  logic [CNT_W-1:0] high_sel;
  logic [CNT_W-1:0] low_sel;
  logic [CNT_W-1:0] count_sel;

  // Tick detect, next pulse number and zero-substituted train parameters.
  // NOTE: every always_comb output gets an unconditional assignment first,
  // so no path through the block can leave a value held (no latch).
  always_comb begin
    tick      = msec & ~msec_d;
    sent_nx   = sent + 1'b1;
    high_sel  = (high_ms == '0) ? CNT_W'(DEF_HIGH) : high_ms;
    low_sel   = (low_ms  == '0) ? CNT_W'(1)        : low_ms;
    count_sel = (count   == '0) ? CNT_W'(1)        : count;
`ifdef IMPULS_TX_ABORT_EN
    abort_req = abort;
`else
    abort_req = 1'b0;
`endif
  end

  // Train sequencer: state, phase countdown and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      msec_d  <= 1'b0;
      rem     <= '0;
      high_l  <= '0;
      low_l   <= '0;
      count_l <= '0;
      impuls  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sent    <= '0;
    end else begin
      msec_d <= msec;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          // A tick coinciding with start is deliberately dropped: ALIGN
          // only reacts to ticks detected after this edge.
          if (start) begin
            high_l  <= high_sel;
            low_l   <= low_sel;
            count_l <= count_sel;
            sent    <= '0;
            busy    <= 1'b1;
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          if (abort_req) begin
            impuls <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (tick) begin
            impuls <= 1'b1;
            rem    <= high_l;
            state  <= HIGH;
          end
        end
        HIGH: begin
          if (abort_req) begin
            impuls <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (tick) begin
            if (rem == CNT_W'(1)) begin
              impuls <= 1'b0;
              sent   <= sent_nx;
              if (sent_nx == count_l) begin
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                rem   <= low_l;
                state <= LOW;
              end
            end else begin
              rem <= rem - 1'b1;
            end
          end
        end
        LOW: begin
          if (abort_req) begin
            impuls <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (tick) begin
            if (rem == CNT_W'(1)) begin
              impuls <= 1'b1;
              rem    <= high_l;
              state  <= HIGH;
            end else begin
              rem <= rem - 1'b1;
            end
          end
        end
        FINISH: begin
          // done was raised on the entry edge; drop it with busy here.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          impuls <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_impuls_tx.sv
// tb_impuls_tx: directed self-checking bench for impuls_tx.
// Define IMPULS_TX_ABORT_EN for both files to also exercise abort.
module tb_impuls_tx;

  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             msec;
  logic             start;
  logic [CNT_W-1:0] high_ms;
  logic [CNT_W-1:0] low_ms;
  logic [CNT_W-1:0] count;
`ifdef IMPULS_TX_ABORT_EN
  logic             abort;
`endif
  logic             impuls;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent;

  impuls_tx #(.CNT_W(CNT_W), .DEF_HIGH(18)) dut (
    .clock   (clock),
    .reset   (reset),
    .msec    (msec),
    .start   (start),
    .high_ms (high_ms),
    .low_ms  (low_ms),
    .count   (count),
`ifdef IMPULS_TX_ABORT_EN
    .abort   (abort),
`endif
    .impuls  (impuls),
    .busy    (busy),
    .done    (done),
    .sent    (sent)
  );

  always #5 clock = ~clock;

  // msec source: free-running square wave (half period `half` cycles) or a
  // level driven directly by the stimulus.
  int   half     = 500;
  int   ph       = 0;
  logic msec_gen = 1'b0;
  logic msec_man = 1'b0;
  logic msec_run = 1'b1;
  assign msec = msec_run ? msec_gen : msec_man;

  always @(negedge clock) begin
    if (ph >= half - 1) begin
      ph       = 0;
      msec_gen = ~msec_gen;
    end else begin
      ph = ph + 1;
    end
  end

  // Monitor: pulse widths, gap widths, pulse count, sent at each fall, dones.
  int   cyc       = 0;
  int   rise_cyc  = 0;
  int   fall_cyc  = 0;
  int   last_high = 0;
  int   last_low  = 0;
  int   n_high    = 0;
  int   done_cnt  = 0;
  int   sent_log [64];
  logic imp_prev  = 1'b0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (impuls === 1'b1 && imp_prev === 1'b0) begin
      if (n_high > 0) last_low = cyc - fall_cyc;
      rise_cyc = cyc;
    end
    if (impuls === 1'b0 && imp_prev === 1'b1) begin
      last_high = cyc - rise_cyc;
      fall_cyc  = cyc;
      if (n_high < 64) sent_log[n_high] = int'(sent);
      n_high = n_high + 1;
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
    imp_prev = impuls;
  end

  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pulse(input int want_sent, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (impuls === 1'b1 && int'(sent) == want_sent) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One manual msec rising edge, ticks spaced 8 cycles apart.
  task automatic tick_man();
    msec_man = 1'b0;
    repeat (4) step();
    msec_man = 1'b1;
    repeat (4) step();
  endtask

  bit ok;
  int d0;
  int n0;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    high_ms = '0;
    low_ms  = '0;
    count   = '0;
`ifdef IMPULS_TX_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (3) step();
    check("rst_impuls", impuls, 0);
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_sent",   sent,   0);
    reset = 1'b0;
    step();

    // Defaults: one pulse of DEF_HIGH = 18 ticks, tick period 1000 cycles.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy_after_start", busy,   1);
    check("t1_impuls_in_align",  impuls, 0);
    d0 = done_cnt;
    wait_done(25000, ok);
    check("t1_done_seen",      ok,     1);
    check("t1_sent",           sent,   1);
    check("t1_impuls_low",     impuls, 0);
    check("t1_busy_with_done", busy,   1);
    step();
    check("t1_done_one_cycle", done,   0);
    check("t1_busy_dropped",   busy,   0);
    check("t1_high_cycles",    last_high, 18000);
    check("t1_done_count",     done_cnt - d0, 1);

    // Train: 4 pulses, 3 ticks high, 2 ticks low, tick period 10 cycles.
    half = 5;
    repeat (20) step();
    high_ms = 8'd3;
    low_ms  = 8'd2;
    count   = 8'd4;
    start   = 1'b1;
    step();
    start = 1'b0;
    n0 = n_high;
    d0 = done_cnt;
    wait_done(500, ok);
    check("t2_done_seen", ok,   1);
    check("t2_sent",      sent, 4);
    step();
    check("t2_pulses",      n_high - n0, 4);
    check("t2_high_cycles", last_high, 30);
    check("t2_low_cycles",  last_low,  20);
    for (int k = 0; k < 4; k++)
      check($sformatf("t2_sent_after_pulse%0d", k + 1), sent_log[n0 + k], k + 1);
    check("t2_done_count", done_cnt - d0, 1);

    // Busy rejection: a second start with high_ms=9 mid-pulse is ignored.
    high_ms = 8'd5;
    low_ms  = 8'd0;
    count   = 8'd1;
    n0 = n_high;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start   = 1'b0;
    high_ms = 8'd9;
    wait_pulse(0, 50, ok);
    check("t3_pulse_started", ok, 1);
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_still_busy", busy, 1);
    wait_done(200, ok);
    check("t3_done_seen", ok, 1);
    step();
    check("t3_high_cycles", last_high, 50);
    repeat (100) step();
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_pulses",     n_high - n0,   1);
    check("t3_idle_busy",  busy, 0);

    // Start coincident with a tick; low_ms=0 gives a 1-tick gap, count=2.
    msec_run = 1'b0;
    msec_man = 1'b0;
    repeat (5) step();
    d0 = done_cnt;
    high_ms  = 8'd2;
    low_ms   = 8'd0;
    count    = 8'd2;
    start    = 1'b1;
    msec_man = 1'b1;
    step();
    start = 1'b0;
    check("t4_busy", busy, 1);
    repeat (6) step();
    check("t4_coincident_tick_ignored", impuls, 0);
    tick_man();
    check("t4_rise_on_next_tick", impuls, 1);
    tick_man();
    check("t4_high_mid", impuls, 1);
    tick_man();
    check("t4_fall_after_2", impuls, 0);
    check("t4_sent_1",       sent,   1);
    tick_man();
    check("t4_gap_one_tick", impuls, 1);
    tick_man();
    tick_man();
    check("t4_sent_2",      sent, 2);
    check("t4_busy_end",    busy, 0);
    check("t4_done_count",  done_cnt - d0, 1);
    check("t4_low_cycles",  last_low,  8);
    check("t4_high_cycles", last_high, 16);

    // Reset while impuls is high in the second pulse.
    msec_run = 1'b1;
    repeat (20) step();
    high_ms = 8'd4;
    low_ms  = 8'd2;
    count   = 8'd3;
    start   = 1'b1;
    step();
    start = 1'b0;
    d0 = done_cnt;
    wait_pulse(1, 300, ok);
    check("t5_second_pulse", ok, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_impuls", impuls, 0);
    check("t5_busy",   busy,   0);
    check("t5_sent",   sent,   0);
    check("t5_done",   done,   0);
    repeat (200) step();
    check("t5_no_done",     done_cnt - d0, 0);
    check("t5_impuls_idle", impuls, 0);

`ifdef IMPULS_TX_ABORT_EN
    // Abort during the second pulse of a 3-pulse train.
    high_ms = 8'd3;
    low_ms  = 8'd2;
    count   = 8'd3;
    start   = 1'b1;
    step();
    start = 1'b0;
    d0 = done_cnt;
    wait_pulse(1, 300, ok);
    check("t6_second_pulse", ok, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6_impuls", impuls, 0);
    check("t6_busy",   busy,   0);
    check("t6_sent",   sent,   1);
    check("t6_done",   done,   0);
    repeat (100) step();
    check("t6_no_done",     done_cnt - d0, 0);
    check("t6_impuls_idle", impuls, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/impuls_tx.md
# impuls_tx

Millisecond-timed impulse transmitter: on a start strobe it drives the `impuls` line high for a programmed number of msec ticks, then low, repeating for a programmed pulse count. It is the sending end of the impulse link whose receiver stretches incoming pulses into an 18 ms `imp` flag. It sits on the `clk_1MHz` domain next to the msec timer and is started by the control FSM.

## Interface
- `CNT_W`, 8: width of the duration and count fields.
- `DEF_HIGH`, 18: high duration in ms used when `high_ms` = 0.
- `clock` in 1: system clock (`clk_1MHz`).
- `reset` in 1: synchronous, active-high reset.
- `msec` in 1: millisecond timer level from the same clock domain. Each rising edge is one tick.
- `start` in 1: single-cycle request. Sampled only in IDLE.
- `high_ms` in CNT_W: high-phase length in ticks. 0 selects `DEF_HIGH`.
- `low_ms` in CNT_W: gap between pulses in ticks. 0 is treated as 1.
- `count` in CNT_W: number of pulses. 0 is treated as 1.
- `abort` in 1: present only with `IMPULS_TX_ABORT_EN`.
- `impuls` out 1: transmitted line, registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle strobe when a train completes normally.
- `sent` out CNT_W: pulses completed in the current or last train.

## Operation
- Tick detect: `msec_d` register. `tick` = `msec & ~msec_d`. `msec_d` resets to 0.
- Parameters are latched on an accepted `start`, with zero substitution applied. Input changes during a train have no effect.
- States:
  - IDLE: `impuls`=0, `busy`=0. On `start` → latch, clear `sent` → ALIGN. A tick in the same cycle as `start` is ignored.
  - ALIGN: wait for `tick`. On `tick`: `impuls`←1, `rem`←`high_ms` → HIGH. The pulse therefore starts on a tick boundary.
  - HIGH: on `tick`, `rem`←`rem`−1. When `rem`=1 and `tick`: `impuls`←0, `sent`←`sent`+1.
    - If `sent`+1 = `count` → FINISH.
    - Else `rem`←`low_ms` → LOW.
  - LOW: on `tick`, decrement. When `rem`=1 and `tick`: `impuls`←1, `rem`←`high_ms` → HIGH.
  - FINISH: `done`=1 for one cycle → IDLE. There is no trailing low phase.
- `start` while `busy` is ignored and not queued.
- `rem` is CNT_W bits and never wraps, because it is never decremented from 0.
- `sent` saturates by construction at `count`, at most 2^CNT_W−1.

## Timing
- Reset values: `impuls`=0, `busy`=0, `done`=0, `sent`=0, state IDLE, `rem`=0, `msec_d`=0.
- `start` at edge t → `busy`=1 after edge t.
- `impuls` rises on the edge at which the first tick after start is sampled. Worst-case latency is 1 ms plus 1 cycle.
- High phase lasts exactly `high_ms` tick periods, edge to edge. Low phase lasts exactly `low_ms` tick periods.
- `done` asserts on the cycle after the edge where the final `impuls` fall is registered. `busy` drops together with `done`'s deassertion.
- `reset` mid-train: all outputs return to reset values on that edge and no `done` is issued.
- `msec` held high produces a single tick. The next tick requires `msec` to return low first.

## Configuration
- `IMPULS_TX_ABORT_EN` defined:
  - Adds the `abort` port.
  - `abort`=1 in ALIGN, HIGH or LOW forces `impuls`←0 and IDLE on the next edge.
  - No `done`; `sent` keeps the completed-pulse count.
  - `abort` has priority over a simultaneous tick.
  - `abort` in IDLE or FINISH has no effect.
- Undefined: no `abort` port. A train runs to completion or until `reset`.

## Test plan
- Defaults: `start`, `high_ms`=0, `count`=0, with `msec` toggling every 500 cycles → one pulse of 18 ticks (18000 cycles). Then `done` for 1 cycle, `sent`=1, `busy`=0.
- Train: `high_ms`=3, `low_ms`=2, `count`=4 → 4 pulses of 3 ms high separated by 2 ms low. `sent` steps 1..4 and `done` follows the 4th fall.
- Busy rejection: second `start` with `high_ms`=9 during a `high_ms`=5 pulse → the high phase stays 5 ticks and only one `done` is issued.
- Start coincident with a tick → `impuls` rises on the following tick, not the coincident one. `low_ms`=0, `count`=2 → the gap is 1 tick.
- Reset while `impuls`=1 mid-train → `impuls`, `busy` and `sent` are 0 after that edge, and no `done` is issued.
- With `IMPULS_TX_ABORT_EN`: `abort` during the 2nd pulse of a `count`=3 train → `impuls`=0 next edge, state IDLE, `sent`=1, no `done`.
